inv_cipher: RTL
===============

INV_CIPHER -- requirements
Module: inv_cipher

Interface
REQ-001 SHALL provide parameter Nk, default 4, key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 SHALL provide parameter Nr, default 10, round count; legal values are 10, 12 and 14, paired with Nk 4, 6 and 8 respectively.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port in, input, 128 bits: ciphertext block.
REQ-006 SHALL provide port key, input, Nk*32 bits: cipher key.
REQ-007 SHALL provide port in_valid, input, 1 bit: in and key are valid.
REQ-008 SHALL provide port in_ready, output, 1 bit: block can accept a request.
REQ-009 SHALL provide port out, output, 128 bits: plaintext block.
REQ-010 SHALL provide port out_valid, output, 1 bit: out holds a result.
REQ-011 SHALL provide port out_ready, input, 1 bit: consumer accepts out.
REQ-012 SHALL index every vector [0:N-1] with byte 0 at the MSB and column-major state, matching the encrypt-side cipher block bit for bit.

Function
REQ-013 SHALL implement the FIPS-197 InvCipher, so that cipher followed by inv_cipher with the same key returns the original block.
REQ-014 SHALL use FSM states IDLE, KEYEXP, INIT, ROUND, FINAL and DONE.
REQ-015 SHALL assert in_ready only in IDLE; a request is accepted on an edge where in_valid and in_ready are both 1.
REQ-016 SHALL, on acceptance, latch in, load w[0..Nk-1] from key, set word counter i = Nk, and go to KEYEXP.
REQ-017 SHALL, in KEYEXP, compute one schedule word per cycle: w[i] = w[i-Nk] ^ f(w[i-1]), where f applies RotWord, SubWord and Rcon when i%Nk==0, applies SubWord when Nk>6 and i%Nk==4, and is identity otherwise; after w[4*Nr+3] the FSM goes to INIT.
REQ-018 SHALL, in INIT, set state = ciphertext ^ round key Nr, set round = Nr-1, and go to ROUND.
REQ-019 SHALL, in each ROUND cycle, set state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[round]) and decrement round; the FSM goes to FINAL after the round==1 cycle.
REQ-020 SHALL, in FINAL, register out = InvSubBytes(InvShiftRows(state)) ^ rk[0], set out_valid, and go to DONE.
REQ-021 SHALL, in DONE, hold out and out_valid stable until out_ready is 1; the FSM then returns to IDLE, out_valid clears, and out retains its value.
REQ-022 SHALL keep in_ready at 0 during the out_ready cycle in DONE; the next request can be accepted no earlier than the following cycle.
REQ-023 SHALL ignore in_valid while busy, without latching data and without any error indication.
REQ-024 SHALL implement InvMixColumns as xtime chains for the multipliers {0e}, {0b}, {0d} and {09}; no multiplier lookup tables.
REQ-025 SHALL have a latency, from the accepting edge to the edge that raises out_valid, of (4*Nr+4-Nk) + Nr + 1 cycles when the key is expanded: 51 for AES-128, 67 for AES-256.

Reset
REQ-026 SHALL, on rst, clear out, out_valid, the state register and the key schedule to 0, and set the FSM to IDLE (in_ready = 1 on the next cycle).
REQ-027 SHALL, on rst asserted mid-operation, abandon the operation with no out_valid pulse, and clear any cached-key validity.
REQ-028 SHALL give rst priority over in_valid and out_ready on the same edge.

Configuration
REQ-029 SHALL, when INV_CIPHER_KEY_CACHE_EN is defined, store the last fully expanded key and a valid flag; an accepted key equal to it with the flag set skips KEYEXP and goes to INIT, giving a latency of Nr+1 cycles (11 for AES-128).
REQ-030 SHALL, when INV_CIPHER_KEY_CACHE_EN is undefined, always run KEYEXP and contain no cache storage.

Verification
REQ-031 Bench SHALL apply Nk=4, key 000102030405060708090a0b0c0d0e0f, in 69c4e0d86a7b0430d8cdb78070b4c55a and require out = 00112233445566778899aabbccddeeff with out_valid 51 cycles after acceptance.
REQ-032 Bench SHALL apply Nk=8/Nr=14, key 000102...1e1f, in 8ea2b7ca516745bfeafc49904b496089 and require out = 00112233445566778899aabbccddeeff after 67 cycles.
REQ-033 Bench SHALL apply key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 with out_ready held 0 for 5 cycles, and require out = 3243f6a8885a308d313198a2e0370734 held stable with in_ready=0 throughout.
REQ-034 Bench SHALL pulse rst during ROUND, then submit the C.1 vector, and require no stale out_valid and a correct result after 51 cycles.
REQ-035 Bench SHALL, with INV_CIPHER_KEY_CACHE_EN defined, send the C.1 vector twice and require latencies of 51 then 11 with identical out, then a different key giving latency 51.
REQ-036 Bench SHALL drive in_valid=1 with new data while busy and require that data to be ignored and the first result to be unchanged.

Source files
------------

// File: rtl/inv_cipher_if.sv
// ---------------------------------------------------------------------------
// inv_cipher_if -- request/response bundle for the AES inverse cipher.
//
// Parameter
//   Nk        : key length in 32-bit words (4, 6 or 8)
// Signals
//   in        : 128-bit ciphertext block            (master -> slave)
//   key       : Nk*32-bit cipher key                (master -> slave)
//   in_valid  : in/key are valid                    (master -> slave)
//   in_ready  : slave can accept a request          (slave  -> master)
//   out       : 128-bit plaintext block             (slave  -> master)
//   out_valid : out holds a result                  (slave  -> master)
//   out_ready : master accepts out                  (master -> slave)
// ---------------------------------------------------------------------------
interface inv_cipher_if #(
    parameter int Nk = 4
);
    logic [127:0]     in;
    logic [Nk*32-1:0] key;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in, key, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  in, key, in_valid, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/inv_cipher.sv
// ---------------------------------------------------------------------------
// inv_cipher -- iterative FIPS-197 AES inverse cipher (AES-128/192/256).
//
// Flow: accept -> KEYEXP (one schedule word per cycle) -> INIT (AddRoundKey
// with rk[Nr]) -> ROUND (Nr-1 full inverse rounds) -> FINAL (last round, no
// InvMixColumns, registers out) -> DONE (hold until out_ready) -> IDLE.
//
// Parameters
//   Nk : key words (4/6/8);  Nr : rounds (10/12/14), paired with Nk
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : inv_cipher_if.slave (in, key, in_valid, in_ready,
//                              out, out_valid, out_ready)
// Optional feature
//   INV_CIPHER_KEY_CACHE_EN : when defined, the last fully expanded key is
//   remembered; a request with the same key skips KEYEXP.
// ---------------------------------------------------------------------------
module inv_cipher #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic         clk,
    input  logic         rst,
    inv_cipher_if.slave  bus
);
    localparam int NW = 4 * (Nr + 1);   // schedule words

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL, DONE} fsm_t;

    // ---------------- GF(2^8) helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = a^-1 (and 0 -> 0); avoids a 256-entry table
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox(w[8*k +: 8]);
        return r;
    endfunction

    // Byte k lives at bits [127-8k -: 8]; row = k%4, column = k/4.
    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        return o;
    endfunction

    // {09},{0b},{0d},{0e} built from the x2/x4/x8 xtime chain
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int k = 0; k < 4; k++) begin
            a[k]  = col[31-8*k -: 8];
            x2    = xtime(a[k]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[k] = x8 ^ a[k];
            mb[k] = x8 ^ x2 ^ a[k];
            md[k] = x8 ^ x4 ^ a[k];
            me[k] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    // ---------------- state ----------------
    fsm_t         state_q, state_d;
    logic [31:0]  w_arr [NW];
    logic [127:0] blk_q, st_q, out_q;
    logic         out_valid_q;
    logic [5:0]   i_q;       // schedule word being produced
    logic [2:0]   kc_q;      // i_q % Nk, kept incrementally to avoid a divider
    logic [7:0]   rcon_q;
    logic [3:0]   rnd_q;

    logic         accept, hit, load_key, last_word;
    logic [31:0]  w_prev, w_old, w_tmp, w_new;
    logic [3:0]   rk_idx;
    logic [5:0]   rk_base;
    logic [127:0] rk, core, round_out;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign load_key  = accept && !hit;
    assign last_word = (i_q == 6'(NW - 1));

`ifdef INV_CIPHER_KEY_CACHE_EN
    logic [Nk*32-1:0] ckey_q;
    logic             cvalid_q;

    assign hit = cvalid_q && (bus.key == ckey_q);

    // Valid only once a schedule has been expanded to the end; a new key
    // overwrites w[0..Nk-1], so the flag drops the moment it is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            ckey_q   <= '0;
            cvalid_q <= 1'b0;
        end else if (load_key) begin
            ckey_q   <= bus.key;
            cvalid_q <= 1'b0;
        end else if (state_q == KEYEXP && last_word) begin
            cvalid_q <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // ---------------- key schedule ----------------
    assign w_prev = w_arr[i_q - 6'd1];
    assign w_old  = w_arr[i_q - 6'(Nk)];

    always_comb begin
        w_tmp = w_prev;
        if (kc_q == 3'd0)
            w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
        else if (Nk > 6 && kc_q == 3'd4)
            w_tmp = sub_word(w_prev);
    end
    assign w_new = w_old ^ w_tmp;

    for (genvar gi = 0; gi < NW; gi++) begin : g_w
        logic [31:0] word_q;
        always_ff @(posedge clk) begin
            if (rst)
                word_q <= '0;
            else if (gi < Nk) begin
                if (load_key) word_q <= bus.key[(Nk-1-gi)*32 +: 32];
            end else if (state_q == KEYEXP && i_q == 6'(gi))
                word_q <= w_new;
        end
        assign w_arr[gi] = word_q;
    end

    // ---------------- round datapath ----------------
    always_comb begin
        rk_idx = 4'd0;
        if (state_q == INIT)       rk_idx = 4'(Nr);
        else if (state_q == ROUND) rk_idx = rnd_q;
    end
    assign rk_base   = {rk_idx, 2'b00};
    assign rk        = {w_arr[rk_base], w_arr[rk_base + 6'd1],
                        w_arr[rk_base + 6'd2], w_arr[rk_base + 6'd3]};
    assign core      = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk;
    assign round_out = inv_mix_columns(core);

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = hit ? INIT : KEYEXP;
            KEYEXP:  if (last_word) state_d = INIT;
            INIT:    state_d = ROUND;
            ROUND:   if (rnd_q == 4'd1) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            st_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            i_q         <= '0;
            kc_q        <= '0;
            rcon_q      <= '0;
            rnd_q       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (accept) begin
                    blk_q  <= bus.in;
                    i_q    <= 6'(Nk);
                    kc_q   <= '0;
                    rcon_q <= 8'h01;
                end
                KEYEXP: begin
                    i_q  <= i_q + 6'd1;
                    kc_q <= (kc_q == 3'(Nk - 1)) ? 3'd0 : kc_q + 3'd1;
                    if (kc_q == 3'd0) rcon_q <= xtime(rcon_q);
                end
                INIT: begin
                    st_q  <= blk_q ^ rk;
                    rnd_q <= 4'(Nr - 1);
                end
                ROUND: begin
                    st_q  <= round_out;
                    rnd_q <= rnd_q - 4'd1;
                end
                FINAL: begin
                    out_q       <= core;
                    out_valid_q <= 1'b1;
                end
                DONE: if (bus.out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule
